// File: rtl/mod3_job_scheduler_pkg.sv
// Shared types and helpers for the mod-3 job scheduler: FSM state encoding,
// default operand width and requester-id width.
package mod3_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEFAULT_DATA_W = 64;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod3_job_scheduler_if.sv
// Bundle of requester-side and unit-side signals of the mod-3 job scheduler.
// slave = scheduler side, master = requesters plus the external unit.
interface mod3_job_scheduler_if
  import mod3_sched_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = DEFAULT_DATA_W
) ();
  localparam int ID_W = id_w(N);

  logic [N-1:0]        req;
  logic [N*DATA_W-1:0] req_x;
  logic [N-1:0]        gnt;
  logic                busy;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [1:0]          rsp_s;
  logic                rsp_err;
  logic [DATA_W-1:0]   u_x;
  logic                u_e;
  logic                u_f;
  logic [1:0]          u_s;

  modport slave (
    input  req, req_x, u_f, u_s,
    output gnt, busy, rsp_valid, rsp_id, rsp_s, rsp_err, u_x, u_e
  );

  modport master (
    output req, req_x, u_f, u_s,
    input  gnt, busy, rsp_valid, rsp_id, rsp_s, rsp_err, u_x, u_e
  );
endinterface

// File: rtl/mod3_job_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward and wrapping.
module rr_arbiter
  import mod3_sched_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = id_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    onehot,
  output logic [ID_W-1:0] idx,
  output logic            any
);
  localparam logic [ID_W:0] N_V = (ID_W + 1)'(N);

  logic [2*N-1:0]  dbl;
  logic [N-1:0]    rot;
  logic [ID_W-1:0] off;
  logic [ID_W:0]   sum;
  logic [ID_W:0]   wrapped;

  // Rotate so that bit 0 is the requester at ptr; the lowest set bit is the winner.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];

  always_comb begin
    off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = ID_W'(j);
    end
  end

  assign sum     = {1'b0, ptr} + {1'b0, off};
  assign wrapped = (sum >= N_V) ? (sum - N_V) : sum;
  assign idx     = wrapped[ID_W-1:0];
  assign any     = |req;
  assign onehot  = any ? (N'(1) << idx) : '0;
endmodule

// File: rtl/mod3_job_scheduler.sv
// Shares one external serial mod-3 unit among N requesters: round-robin accept,
// clear the unit, run it until done or timeout, then report a tagged remainder.
module mod3_job_scheduler
  import mod3_sched_pkg::*;
#(
  parameter int N              = 4,
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int CLEAR_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                 clk,
  input logic                 rst,
  mod3_job_scheduler_if.slave bus
);
  localparam int ID_W    = id_w(N);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > CLEAR_CYCLES) ? TIMEOUT_CYCLES : CLEAR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST    = ID_W'(N - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   cur_id;
  logic [ID_W-1:0]   rr_ptr;

  logic [N-1:0]      gnt_r;
  logic              busy_r;
  logic              rsp_valid_r;
  logic [ID_W-1:0]   rsp_id_r;
  logic [1:0]        rsp_s_r;
  logic              rsp_err_r;
  logic [DATA_W-1:0] u_x_r;
  logic              u_e_r;

  logic [N-1:0]      win_onehot;
  logic [ID_W-1:0]   win_idx;
  logic              win_any;

  rr_arbiter #(
    .N    (N),
    .ID_W (ID_W)
  ) u_arb (
    .req    (bus.req),
    .ptr    (rr_ptr),
    .onehot (win_onehot),
    .idx    (win_idx),
    .any    (win_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cur_id      <= '0;
      rr_ptr      <= '0;
      gnt_r       <= '0;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_s_r     <= 2'd0;
      rsp_err_r   <= 1'b0;
      u_x_r       <= '0;
      u_e_r       <= 1'b0;
    end else begin
      gnt_r       <= '0;
      rsp_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (win_any) begin
            gnt_r  <= win_onehot;
            u_x_r  <= bus.req_x[win_idx*DATA_W +: DATA_W];
            cur_id <= win_idx;
            busy_r <= 1'b1;
            cnt    <= '0;
            state  <= CLEAR;
          end
        end
        CLEAR: begin
          if (cnt == CLEAR_LAST) begin
            cnt   <= '0;
            u_e_r <= 1'b1;
            state <= RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          // Done takes priority over a timeout landing on the same edge.
          if (bus.u_f || (cnt == TO_LAST)) begin
            rsp_s_r     <= bus.u_f ? bus.u_s : 2'd0;
            rsp_err_r   <= ~bus.u_f;
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= cur_id;
            u_e_r       <= 1'b0;
            cnt         <= '0;
            state       <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          rr_ptr <= (cur_id == ID_LAST) ? '0 : cur_id + 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.busy      = busy_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_s     = rsp_s_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.u_x       = u_x_r;
  assign bus.u_e       = u_e_r;
endmodule
